// File: rtl/twiddle60_addr_seq.sv
// Address sequencer for the 60-entry twiddle ROM of a two-factor DFT (N = N1*N2 dividing 60).
// Optional conjugate (IDFT) addressing is enabled by defining TWSEQ_CONJ_EN.
module twiddle60_addr_seq #(
    parameter int TW_LAT = 0,
    parameter int AW     = 11
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef TWSEQ_CONJ_EN
    input  logic          inverse,
`endif
    input  logic          start,
    input  logic [5:0]    cfg_n1,
    input  logic [5:0]    cfg_n2,
    input  logic          out_ready,
    output logic [AW-1:0] tw_addr,
    output logic          tw_addr_vld,
    output logic          tw_vld,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam int DW = (TW_LAT > 1) ? $clog2(TW_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = (TW_LAT > 0) ? DW'(TW_LAT - 1) : '0;

    state_t        state_reg, state_next;
    logic [5:0]    n1_max_reg, n1_max_next;
    logic [5:0]    n2_max_reg, n2_max_next;
    logic [5:0]    n1_reg, n1_next;
    logic [5:0]    k2_reg, k2_next;
    logic [5:0]    s_reg, s_next;
    logic [5:0]    step_reg, step_next;
    logic [5:0]    acc_reg, acc_next;
    logic [DW-1:0] drain_cnt_reg, drain_cnt_next;
    logic          cfg_err_reg, cfg_err_next;
    logic [5:0]    addr_sel;
    logic          xfer;

    // Legality and stride: N must be one of the twelve divisors of 60; S = 60/N kept mod 60.
    logic [11:0]   cfg_prod;
    logic          cfg_legal;
    logic [5:0]    cfg_s;

    assign cfg_prod = cfg_n1 * cfg_n2;

    always_comb begin
        cfg_legal = 1'b1;
        cfg_s     = 6'd0;
        case (cfg_prod)
            12'd1:   cfg_s = 6'd0;
            12'd2:   cfg_s = 6'd30;
            12'd3:   cfg_s = 6'd20;
            12'd4:   cfg_s = 6'd15;
            12'd5:   cfg_s = 6'd12;
            12'd6:   cfg_s = 6'd10;
            12'd10:  cfg_s = 6'd6;
            12'd12:  cfg_s = 6'd5;
            12'd15:  cfg_s = 6'd4;
            12'd20:  cfg_s = 6'd3;
            12'd30:  cfg_s = 6'd2;
            12'd60:  cfg_s = 6'd1;
            default: cfg_legal = 1'b0;
        endcase
    end

    function automatic logic [5:0] add_mod60(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 7'd60)
            sum = sum - 7'd60;
        return sum[5:0];
    endfunction

    assign tw_addr_vld = (state_reg == ST_RUN);
    assign xfer        = tw_addr_vld & out_ready;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign cfg_err     = cfg_err_reg;
    assign tw_addr     = AW'(addr_sel);

`ifdef TWSEQ_CONJ_EN
    logic inverse_reg, inverse_next;
    // Conjugate twiddle: W^-x = W^(60-x), with index 0 mapping onto itself.
    assign addr_sel = (inverse_reg && (acc_reg != 6'd0)) ? (6'd60 - acc_reg) : acc_reg;
`else
    assign addr_sel = acc_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        n1_max_next    = n1_max_reg;
        n2_max_next    = n2_max_reg;
        n1_next        = n1_reg;
        k2_next        = k2_reg;
        s_next         = s_reg;
        step_next      = step_reg;
        acc_next       = acc_reg;
        drain_cnt_next = drain_cnt_reg;
        cfg_err_next   = 1'b0;
`ifdef TWSEQ_CONJ_EN
        inverse_next   = inverse_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        state_next  = ST_RUN;
                        n1_max_next = cfg_n1 - 6'd1;
                        n2_max_next = cfg_n2 - 6'd1;
                        s_next      = cfg_s;
                        n1_next     = 6'd0;
                        k2_next     = 6'd0;
                        step_next   = 6'd0;
                        acc_next    = 6'd0;
`ifdef TWSEQ_CONJ_EN
                        inverse_next = inverse;
`endif
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (k2_reg == n2_max_reg) begin
                        if (n1_reg == n1_max_reg) begin
                            drain_cnt_next = '0;
                            if (TW_LAT > 0)
                                state_next = ST_DRAIN;
                            else
                                state_next = ST_DONE;
                        end else begin
                            n1_next   = n1_reg + 6'd1;
                            k2_next   = 6'd0;
                            acc_next  = 6'd0;
                            step_next = add_mod60(step_reg, s_reg);
                        end
                    end else begin
                        k2_next  = k2_reg + 6'd1;
                        acc_next = add_mod60(acc_reg, step_reg);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST)
                    state_next = ST_DONE;
                else
                    drain_cnt_next = drain_cnt_reg + 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            n1_max_reg    <= 6'd0;
            n2_max_reg    <= 6'd0;
            n1_reg        <= 6'd0;
            k2_reg        <= 6'd0;
            s_reg         <= 6'd0;
            step_reg      <= 6'd0;
            acc_reg       <= 6'd0;
            drain_cnt_reg <= '0;
            cfg_err_reg   <= 1'b0;
`ifdef TWSEQ_CONJ_EN
            inverse_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            n1_max_reg    <= n1_max_next;
            n2_max_reg    <= n2_max_next;
            n1_reg        <= n1_next;
            k2_reg        <= k2_next;
            s_reg         <= s_next;
            step_reg      <= step_next;
            acc_reg       <= acc_next;
            drain_cnt_reg <= drain_cnt_next;
            cfg_err_reg   <= cfg_err_next;
`ifdef TWSEQ_CONJ_EN
            inverse_reg   <= inverse_next;
`endif
        end
    end

    // tw_vld tracks accepted addresses through the ROM read latency.
    generate
        if (TW_LAT == 0) begin : g_vld_comb
            assign tw_vld = xfer;
        end else begin : g_vld_pipe
            logic [TW_LAT-1:0] vld_pipe_reg;
            for (genvar gi = 0; gi < TW_LAT; gi++) begin : g_stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        vld_pipe_reg[gi] <= 1'b0;
                    else if (gi == 0)
                        vld_pipe_reg[gi] <= xfer;
                    else
                        vld_pipe_reg[gi] <= vld_pipe_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
            assign tw_vld = vld_pipe_reg[TW_LAT-1];
        end
    endgenerate

    a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
        tw_addr_vld |-> (tw_addr < AW'(60)));

endmodule

// File: tb/tb_twiddle60_addr_seq.sv
// Bench for twiddle60_addr_seq: two instances (ROM latency 0 and 1) share stimulus and are
// checked every cycle against an arithmetic model of the n1/k2 sweep.
module tb_twiddle60_addr_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cfg_n1 = 6'd0;
    logic [5:0]  cfg_n2 = 6'd0;
    logic        out_ready = 1'b0;
`ifdef TWSEQ_CONJ_EN
    logic        inverse = 1'b0;
`endif

    logic [10:0] d_addr [2];
    logic        d_avld [2];
    logic        d_vld  [2];
    logic        d_busy [2];
    logic        d_done [2];
    logic        d_err  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    twiddle60_addr_seq #(.TW_LAT(0), .AW(11)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
`ifdef TWSEQ_CONJ_EN
        .inverse(inverse),
`endif
        .start(start), .cfg_n1(cfg_n1), .cfg_n2(cfg_n2), .out_ready(out_ready),
        .tw_addr(d_addr[0]), .tw_addr_vld(d_avld[0]), .tw_vld(d_vld[0]),
        .busy(d_busy[0]), .done(d_done[0]), .cfg_err(d_err[0])
    );

    twiddle60_addr_seq #(.TW_LAT(1), .AW(11)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef TWSEQ_CONJ_EN
        .inverse(inverse),
`endif
        .start(start), .cfg_n1(cfg_n1), .cfg_n2(cfg_n2), .out_ready(out_ready),
        .tw_addr(d_addr[1]), .tw_addr_vld(d_avld[1]), .tw_vld(d_vld[1]),
        .busy(d_busy[1]), .done(d_done[1]), .cfg_err(d_err[1])
    );

    task automatic check(input string name, input int lane, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int a, input int b);
        return (a >= 1) && (b >= 1) && ((60 % (a * b)) == 0);
    endfunction

    // Model, lane index = ROM latency. tail counts cycles after the last transfer.
    bit m_run   [2] = '{0, 0};
    bit m_vld_d [2] = '{0, 0};
    bit m_err   [2] = '{0, 0};
    int m_tail  [2] = '{-1, -1};
    int m_n1    [2] = '{0, 0};
    int m_k2    [2] = '{0, 0};
    int m_cn1   [2] = '{1, 1};
    int m_cn2   [2] = '{1, 1};

    always @(posedge clk or negedge rst_n) begin
        for (int l = 0; l < 2; l++) begin
            if (!rst_n) begin
                m_run[l]   <= 1'b0;
                m_vld_d[l] <= 1'b0;
                m_err[l]   <= 1'b0;
                m_tail[l]  <= -1;
                m_n1[l]    <= 0;
                m_k2[l]    <= 0;
            end else begin
                m_vld_d[l] <= m_run[l] && out_ready;
                m_err[l]   <= 1'b0;
                if (m_tail[l] >= 0) begin
                    m_tail[l] <= (m_tail[l] == l) ? -1 : m_tail[l] + 1;
                end else if (m_run[l]) begin
                    if (out_ready) begin
                        if (m_k2[l] == m_cn2[l] - 1) begin
                            if (m_n1[l] == m_cn1[l] - 1) begin
                                m_run[l]  <= 1'b0;
                                m_tail[l] <= 0;
                            end else begin
                                m_n1[l] <= m_n1[l] + 1;
                                m_k2[l] <= 0;
                            end
                        end else begin
                            m_k2[l] <= m_k2[l] + 1;
                        end
                    end
                end else if (start) begin
                    if (legal(int'(cfg_n1), int'(cfg_n2))) begin
                        m_run[l] <= 1'b1;
                        m_n1[l]  <= 0;
                        m_k2[l]  <= 0;
                        m_cn1[l] <= int'(cfg_n1);
                        m_cn2[l] <= int'(cfg_n2);
                    end else begin
                        m_err[l] <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            check("addr_vld", l, int'(d_avld[l]), int'(m_run[l]));
            check("busy", l, int'(d_busy[l]), int'(m_run[l] || (m_tail[l] >= 0)));
            check("done", l, int'(d_done[l]), int'(m_tail[l] == l));
            check("cfg_err", l, int'(d_err[l]), int'(m_err[l]));
            check("tw_vld", l, int'(d_vld[l]),
                  (l == 0) ? int'(m_run[0] && out_ready) : int'(m_vld_d[1]));
            if (m_run[l])
                check("tw_addr", l, int'(d_addr[l]),
                      (m_n1[l] * m_k2[l] * (60 / (m_cn1[l] * m_cn2[l]))) % 60);
            if (!rst_n)
                check("reset_addr", l, int'(d_addr[l]), 0);
        end
    end

    // Observation log used by the literal per-test expectations.
    int cap[$];
    int vld1_cnt = 0;
    int done0_cnt = 0;
    int err0_cnt = 0;
    int avld0_cnt = 0;

    always @(negedge clk) begin
        if (d_avld[0] && out_ready)
            cap.push_back(int'(d_addr[0]));
        if (d_vld[1])
            vld1_cnt++;
        if (d_done[0])
            done0_cnt++;
        if (d_err[0])
            err0_cnt++;
        if (d_avld[0])
            avld0_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int a, input int b);
        cfg_n1 = 6'(a);
        cfg_n2 = 6'(b);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cfg_n1 = 6'($urandom_range(0, 63));
        cfg_n2 = 6'($urandom_range(0, 63));
    endtask

    function automatic bit lanes_idle();
        return !m_run[0] && !m_run[1] && (m_tail[0] < 0) && (m_tail[1] < 0);
    endfunction

    // mode 0: always ready, 1: ready on alternate cycles, 2: random, 3: random + stray starts
    task automatic run_to_idle(input int mode);
        int c;
        c = 0;
        while (!lanes_idle() && c < 1000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = c[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 3 && m_run[0] && $urandom_range(0, 7) == 0) begin
                start  = 1'b1;
                cfg_n1 = 6'($urandom_range(1, 12));
                cfg_n2 = 6'($urandom_range(1, 12));
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
        end
        start = 1'b0;
        if (c >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: got %0d cycles, required completion below 1000", c);
        end
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    int t1_exp [12] = '{0, 0, 0, 0, 0, 5, 10, 15, 0, 10, 20, 30};

    initial begin
        int b, dn, vb, eb, ab;
        int divs [12] = '{1, 2, 3, 4, 5, 6, 10, 12, 15, 20, 30, 60};

        tick();
        tick();
        check("reset_busy", 0, int'(d_busy[0]), 0);
        check("reset_addr_vld", 1, int'(d_avld[1]), 0);
        rst_n = 1'b1;
        tick();

        // T1: 3x4, full throughput
        b = cap.size(); dn = done0_cnt;
        pulse_start(3, 4);
        run_to_idle(0);
        check("T1_count", 0, cap.size() - b, 12);
        if (cap.size() - b >= 12)
            for (int i = 0; i < 12; i++)
                check("T1_addr", 0, cap[b + i], t1_exp[i]);
        check("T1_done", 0, done0_cnt - dn, 1);
        $display("T1 n1=3 n2=4 transfers=%0d", cap.size() - b);

        // T2: 4x15, row n1=3 and latency-1 valid count
        b = cap.size(); vb = vld1_cnt;
        pulse_start(4, 15);
        run_to_idle(0);
        check("T2_vld_count", 1, vld1_cnt - vb, 60);
        check("T2_count", 0, cap.size() - b, 60);
        if (cap.size() - b >= 60)
            for (int k = 0; k < 15; k++)
                check("T2_row3", 0, cap[b + 45 + k], 3 * k);
        $display("T2 n1=4 n2=15 tw_vld=%0d", vld1_cnt - vb);

        // T3: T1 with alternating backpressure
        b = cap.size(); dn = done0_cnt;
        pulse_start(3, 4);
        run_to_idle(1);
        check("T3_count", 0, cap.size() - b, 12);
        if (cap.size() - b >= 12)
            for (int i = 0; i < 12; i++)
                check("T3_addr", 0, cap[b + i], t1_exp[i]);
        check("T3_done", 0, done0_cnt - dn, 1);
        $display("T3 n1=3 n2=4 backpressure transfers=%0d", cap.size() - b);

        // T4: illegal config, then start ignored during RUN
        eb = err0_cnt; ab = avld0_cnt;
        pulse_start(7, 2);
        tick();
        tick();
        check("T4_cfg_err", 0, err0_cnt - eb, 1);
        check("T4_no_vld", 0, avld0_cnt - ab, 0);
        b = cap.size(); dn = done0_cnt;
        out_ready = 1'b0;
        pulse_start(2, 3);
        tick();
        pulse_start(5, 1);
        run_to_idle(0);
        check("T4_ignored_start", 0, cap.size() - b, 6);
        check("T4_done", 0, done0_cnt - dn, 1);
        $display("T4 illegal n1=7 n2=2 cfg_err=%0d", err0_cnt - eb);

        // T5: reset at transfer 20 of T2, then replay
        b = cap.size(); dn = done0_cnt;
        pulse_start(4, 15);
        out_ready = 1'b1;
        for (int c = 0; c < 200 && (cap.size() - b) < 20; c++)
            tick();
        rst_n = 1'b0;
        #2;
        check("T5_busy", 0, int'(d_busy[0]), 0);
        check("T5_busy", 1, int'(d_busy[1]), 0);
        check("T5_addr_vld", 1, int'(d_avld[1]), 0);
        check("T5_addr", 1, int'(d_addr[1]), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("T5_no_done", 0, done0_cnt - dn, 0);
        b = cap.size();
        pulse_start(4, 15);
        run_to_idle(2);
        check("T5_replay_count", 0, cap.size() - b, 60);
        if (cap.size() - b >= 60) begin
            check("T5_replay_first", 0, cap[b], 0);
            check("T5_replay_n1_1_k2_1", 0, cap[b + 16], 1);
        end
        $display("T5 reset mid-run, replay transfers=%0d", cap.size() - b);

        // Random legal/illegal configurations under random backpressure
        for (int r = 0; r < 10; r++) begin
            int n, n1, n2, pick;
            int dl [$];
            n = divs[$urandom_range(0, 11)];
            for (int d = 1; d <= n; d++)
                if (n % d == 0)
                    dl.push_back(d);
            pick = $urandom_range(0, dl.size() - 1);
            n1 = dl[pick];
            n2 = n / n1;
            if (r == 4) begin
                n1 = 8;
                n2 = 3;
            end
            b = cap.size();
            pulse_start(n1, n2);
            run_to_idle((r % 2 == 0) ? 2 : 3);
            check("RND_count", 0, cap.size() - b, legal(n1, n2) ? n1 * n2 : 0);
            $display("RND n1=%0d n2=%0d transfers=%0d", n1, n2, cap.size() - b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
